// File: rtl/dpram_fifo.sv
// dpram_fifo: first-word-fall-through FIFO over a bypassing dual-port RAM.
// Define DPRAM_FIFO_ALMOST_EN for registered almost_full/almost_empty.
module dpram_fifo #(
  parameter int DEPTH = 16,
  parameter int DATAW = 32
`ifdef DPRAM_FIFO_ALMOST_EN
  ,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 1
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATAW-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATAW-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef DPRAM_FIFO_ALMOST_EN
  ,
  output logic                   almost_full,
  output logic                   almost_empty
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;
  logic             rd;
  logic [CW-1:0]    avail;
  logic [CW-1:0]    count_nxt;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;
  logic [DATAW-1:0] ram_wdata;
  logic [DATAW-1:0] ram_rdata;
  logic [DATAW-1:0] mem [DEPTH];

  assign in_ready  = count < CW'(DEPTH);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign avail     = count - CW'(out_valid);
  assign rd        = (avail != '0) && (!out_valid || pop);
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Without a new read, re-read the head slot so RData holds steady.
  assign ram_we    = push;
  assign ram_waddr = wptr;
  assign ram_wdata = in_data;
  assign ram_raddr = rd ? rptr : rptr - AW'(1);
  assign out_data  = ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (rd) begin
        rptr <= rptr + AW'(1);
      end
      count     <= count_nxt;
      out_valid <= rd ? 1'b1 : (pop ? 1'b0 : out_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // Registered read port with write-to-read bypass on address match.
  always_ff @(posedge clk) begin
    if (ram_we && (ram_waddr == ram_raddr)) begin
      ram_rdata <= ram_wdata;
    end else begin
      ram_rdata <= mem[ram_raddr];
    end
  end

`ifdef DPRAM_FIFO_ALMOST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= count_nxt >= CW'(DEPTH - AF_MARGIN);
      almost_empty <= count_nxt <= CW'(AE_MARGIN);
    end
  end
`endif

endmodule
